// File: rtl/gpio_xbus_pkg.sv
// Shared register map and bus helpers for the gpio_xbus slave.
package gpio_xbus_pkg;

  typedef enum logic [2:0] {
    REG_SW_IN    = 3'd0,
    REG_LED_OUT  = 3'd1,
    REG_LED_SET  = 3'd2,
    REG_LED_CLR  = 3'd3,
    REG_LED_TGL  = 3'd4,
    REG_IRQ_EN   = 3'd5,
    REG_IRQ_STAT = 3'd6,
    REG_RSVD     = 3'd7
  } reg_e;

  localparam logic [2:0] OFF_SW_IN    = 3'd0;
  localparam logic [2:0] OFF_LED_OUT  = 3'd1;
  localparam logic [2:0] OFF_LED_SET  = 3'd2;
  localparam logic [2:0] OFF_LED_CLR  = 3'd3;
  localparam logic [2:0] OFF_LED_TGL  = 3'd4;
  localparam logic [2:0] OFF_IRQ_EN   = 3'd5;
  localparam logic [2:0] OFF_IRQ_STAT = 3'd6;
  localparam logic [2:0] OFF_RSVD     = 3'd7;

  // Expand the four byte enables into a 32-bit bit mask.
  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++)
      if (be[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

endpackage

// File: rtl/gpio_xbus_sw_debounce.sv
// Per-pin 2-flop synchronizer and debouncer; change pulses on the edge stable flips.
module sw_debounce #(
  parameter int DB_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic stable,
  output logic change
);
  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          synced;

  assign synced = sync[1];
  assign change = (synced != stable) && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= '0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync <= {sync[0], din};
      // Any sample matching stable restarts the window.
      if (synced == stable) begin
        cnt <= '0;
      end else if (change) begin
        stable <= synced;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/gpio_xbus.sv
// GPIO slave on xbus: debounced switch inputs with change interrupts, LED output register.
module gpio_xbus
  import gpio_xbus_pkg::*;
#(
  parameter int N_SW      = 8,
  parameter int N_LED     = 8,
  parameter int DB_CYCLES = 65536
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             xbus_cs,
  input  logic             xbus_we,
  input  logic [3:0]       xbus_be,
  input  logic [31:0]      xbus_addr,
  input  logic [31:0]      xbus_wdata,
  output logic [31:0]      xbus_rdata,
  input  logic [N_SW-1:0]  sw,
  output logic [N_LED-1:0] led,
  output logic             irq
);

  logic [31:0]      bmask;
  logic             wr_en;
  reg_e             off;
  logic [N_LED-1:0] led_q, led_d, led_m, led_w;
  logic [N_SW-1:0]  en_q, en_d, stat_q, stat_d, sw_m, sw_w;
  logic [N_SW-1:0]  sw_stable, sw_change;
  logic             unused;

  assign bmask = be_mask(xbus_be);
  assign wr_en = xbus_cs && xbus_we;
  assign off   = reg_e'(xbus_addr[4:2]);
  assign led_m = bmask[N_LED-1:0];
  assign led_w = xbus_wdata[N_LED-1:0] & led_m;
  assign sw_m  = bmask[N_SW-1:0];
  assign sw_w  = xbus_wdata[N_SW-1:0] & sw_m;
  assign unused = ^{xbus_addr[31:5], xbus_addr[1:0], xbus_wdata, bmask};

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .din    (sw[i]),
      .stable (sw_stable[i]),
      .change (sw_change[i])
    );
  end

  always_comb begin
    led_d = led_q;
    en_d  = en_q;
    if (wr_en) begin
      case (off)
        REG_LED_OUT: led_d = (led_q & ~led_m) | led_w;
        REG_LED_SET: led_d = led_q | led_w;
        REG_LED_CLR: led_d = led_q & ~led_w;
        REG_LED_TGL: led_d = led_q ^ led_w;
        REG_IRQ_EN:  en_d  = (en_q & ~sw_m) | sw_w;
        default: ;
      endcase
    end
  end

  // Hardware set is OR'd in after the W1C so a coincident edge wins.
  always_comb begin
    stat_d = stat_q;
    if (wr_en && off == REG_IRQ_STAT) stat_d = stat_q & ~sw_w;
    stat_d = stat_d | sw_change;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q  <= '0;
      en_q   <= '0;
      stat_q <= '0;
      irq    <= 1'b0;
    end else begin
      led_q  <= led_d;
      en_q   <= en_d;
      stat_q <= stat_d;
      irq    <= |(stat_q & en_q);
    end
  end

  assign led = led_q;

  always_comb begin
    xbus_rdata = '0;
    case (off)
      REG_SW_IN:    xbus_rdata[N_SW-1:0]  = sw_stable;
      REG_LED_OUT:  xbus_rdata[N_LED-1:0] = led_q;
      REG_IRQ_EN:   xbus_rdata[N_SW-1:0]  = en_q;
      REG_IRQ_STAT: xbus_rdata[N_SW-1:0]  = stat_q;
      default: ;
    endcase
  end

endmodule
